// File: rtl/arena_scanner_if.sv
// Bundle between the arena scanner, the grid storage and the render stage.
// Carries the frame tick, the grid read port, the tile handshake and the status outputs.
// The master modport is the scanner side. The slave modport is the grid/render side.
interface arena_scanner_if;
  logic       start;
  logic [3:0] rd_row;
  logic [3:0] rd_col;
  logic [1:0] arena_q;
  logic [1:0] bomb_q;
  logic       tile_valid;
  logic       tile_ready;
  logic [2:0] tile_code;
  logic [3:0] tile_row;
  logic [3:0] tile_col;
  logic       tile_last;
  logic       busy;
  logic       done;
  logic [7:0] frame_cnt;

  modport master (
    input  start, arena_q, bomb_q, tile_ready,
    output rd_row, rd_col, tile_valid, tile_code, tile_row, tile_col,
           tile_last, busy, done, frame_cnt
  );

  modport slave (
    output start, arena_q, bomb_q, tile_ready,
    input  rd_row, rd_col, tile_valid, tile_code, tile_row, tile_col,
           tile_last, busy, done, frame_cnt
  );
endinterface

// File: rtl/arena_scanner.sv
// Scans the arena/bomb grids row-major on a frame tick and streams merged 3-bit tile codes.
// Latency: 3 cycles per cell (ADDR, CAPT, SEND); done pulses 3*ROWS*COLS+1 cycles after start.
// Backpressure: a tile waits in SEND with all fields and read address frozen until tile_ready.
// Ports: clk, rst (async active-high); bus = arena_scanner_if.master carrying start,
//   the grid read port (rd_row/rd_col -> arena_q/bomb_q, one-cycle latency), the tile
//   valid/ready stream (tile_code/row/col/last) and status (busy, done, frame_cnt).
module arena_scanner #(
  parameter int ROWS = 10,
  parameter int COLS = 10
) (
  input  logic            clk,
  input  logic            rst,
  arena_scanner_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ADDR = 3'd1;
  localparam logic [2:0] CAPT = 3'd2;
  localparam logic [2:0] SEND = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  logic [2:0] state;
  logic [3:0] row;
  logic [3:0] col;
  logic [2:0] code_r;
  logic [3:0] trow_r;
  logic [3:0] tcol_r;
  logic       last_r;
  logic [7:0] frame_r;

  // Block beats bomb, player standing on a bomb gets its own code, a bare bomb
  // maps its fuse stage onto 4..6.
  function automatic logic [2:0] merge(input logic [1:0] a, input logic [1:0] b);
    if (b == 2'd0)      return {1'b0, a};
    else if (a == 2'd0) return 3'd3 + {1'b0, b};
    else if (a == 2'd1) return 3'd1;
    else                return 3'd7;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      code_r  <= '0;
      trow_r  <= '0;
      tcol_r  <= '0;
      last_r  <= 1'b0;
      frame_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            row   <= '0;
            col   <= '0;
            state <= ADDR;
          end
        end
        // Address is already on rd_row/rd_col; grid data arrives next cycle.
        ADDR: state <= CAPT;
        CAPT: begin
          code_r <= merge(bus.arena_q, bus.bomb_q);
          trow_r <= row;
          tcol_r <= col;
          last_r <= (row == LAST_ROW) && (col == LAST_COL);
          state  <= SEND;
        end
        SEND: begin
          if (bus.tile_ready) begin
            if (last_r) begin
              // Counted on entry to DONE so the new value is visible with done.
              frame_r <= frame_r + 8'd1;
              state   <= DONE;
            end else begin
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 4'd1;
              end else begin
                col <= col + 4'd1;
              end
              state <= ADDR;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Counters only move on acceptance, so the read address is stable across stalls.
  assign bus.rd_row     = row;
  assign bus.rd_col     = col;
  assign bus.tile_valid = (state == SEND);
  assign bus.tile_code  = code_r;
  assign bus.tile_row   = trow_r;
  assign bus.tile_col   = tcol_r;
  assign bus.tile_last  = last_r;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.frame_cnt  = frame_r;

endmodule

// File: tb/tb_arena_scanner.sv
// Directed bench for arena_scanner: grid memory model with one-cycle read latency,
// per-tile checks against a merge model, reset, backpressure, ignored start and frame wrap.
// Ports of the DUT are reached through an arena_scanner_if instance.
module tb_arena_scanner;
  logic clk = 1'b0;
  logic rst;
  arena_scanner_if sif ();

  arena_scanner #(.ROWS(10), .COLS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.master)
  );

  always #5 clk = ~clk;

  logic [1:0] arena_m [0:9][0:9];
  logic [1:0] bomb_m  [0:9][0:9];

  always @(posedge clk) begin
    sif.arena_q <= arena_m[sif.rd_row][sif.rd_col];
    sif.bomb_q  <= bomb_m[sif.rd_row][sif.rd_col];
  end

  int checks = 0;
  int failures = 0;
  int got_code [0:99];
  int last_cnt;
  int last_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_code(input logic [1:0] a, input logic [1:0] b);
    case (a)
      2'd0:    return (b == 2'd0) ? 3'd0 : 3'(int'(b) + 3);
      2'd1:    return 3'd1;
      default: return (b == 2'd0) ? {1'b0, a} : 3'd7;
    endcase
  endfunction

  // One scan from a start tick. stall_n: cycles to hold tile_ready low on tile (2,4).
  // pulse: raise start while tile (3,0) is presented. full: per-tile field checks.
  task automatic scan(input int stall_n, input bit pulse, input bit full,
                      output int tiles, output int done_cyc, output int fc);
    int cyc;
    int n;
    int stall;
    @(negedge clk);
    sif.start = 1'b1;
    sif.tile_ready = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    cyc = 1; n = 0; stall = 0; done_cyc = -1; fc = -1;
    last_cnt = 0; last_idx = -1;
    if (full) check("busy_after_start", sif.busy, 1'b1);
    while (cyc <= 400 + stall_n && done_cyc < 0) begin
      sif.start = 1'b0;
      if (sif.done) begin
        done_cyc = cyc;
        fc = int'(sif.frame_cnt);
      end else if (sif.tile_valid) begin
        if (full && n == 0) check("first_valid_cycle", cyc, 3);
        if (stall_n > 0 && n == 24 && stall < stall_n) begin
          sif.tile_ready = 1'b0;
          stall++;
          check("stall_valid", sif.tile_valid, 1'b1);
          check("stall_tile_row", sif.tile_row, 2);
          check("stall_tile_col", sif.tile_col, 4);
          check("stall_rd_row", sif.rd_row, 2);
          check("stall_rd_col", sif.rd_col, 4);
          check("stall_tile_code", sif.tile_code, exp_code(arena_m[2][4], bomb_m[2][4]));
        end else begin
          sif.tile_ready = 1'b1;
          if (n < 100) begin
            got_code[n] = int'(sif.tile_code);
            if (full) begin
              check("tile_row", sif.tile_row, n / 10);
              check("tile_col", sif.tile_col, n % 10);
              check("tile_code", sif.tile_code, exp_code(arena_m[n / 10][n % 10], bomb_m[n / 10][n % 10]));
            end
          end
          if (sif.tile_last) begin
            last_cnt++;
            last_idx = n;
          end
          if (pulse && n == 30) sif.start = 1'b1;
          n++;
        end
      end
      if (done_cyc < 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    sif.start = 1'b0;
    sif.tile_ready = 1'b1;
    check("scan_done_seen", done_cyc >= 0, 1'b1);
    @(negedge clk);
    check("idle_after_done_busy", sif.busy, 1'b0);
    check("idle_after_done_done", sif.done, 1'b0);
    tiles = n;
  endtask

  initial begin
    int tiles;
    int dc;
    int fc;
    int k;
    rst = 1'b1;
    sif.start = 1'b0;
    sif.tile_ready = 1'b1;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        arena_m[r][c] = (r == 0 || r == 9 || c == 0 || c == 9) ? 2'd1 : 2'd0;
        bomb_m[r][c] = 2'd0;
      end
    end
    arena_m[1][1] = 2'd2;
    arena_m[8][8] = 2'd3;
    arena_m[1][3] = 2'd1;
    arena_m[5][7] = 2'd1;

    repeat (2) @(negedge clk);
    check("rst_busy", sif.busy, 1'b0);
    check("rst_valid", sif.tile_valid, 1'b0);
    check("rst_frame_cnt", sif.frame_cnt, 0);
    rst = 1'b0;

    // Reset mid-scan while tile (1,1) is presented.
    @(negedge clk);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    k = 0;
    while (k < 200 && !(sif.tile_valid && sif.tile_row == 4'd1 && sif.tile_col == 4'd1)) begin
      @(negedge clk);
      k++;
    end
    check("pre_reset_tile_seen", k < 200, 1'b1);
    check("pre_reset_code", sif.tile_code, 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", sif.tile_valid, 1'b0);
    check("mid_rst_code", sif.tile_code, 0);
    check("mid_rst_row", sif.tile_row, 0);
    check("mid_rst_col", sif.tile_col, 0);
    check("mid_rst_last", sif.tile_last, 1'b0);
    check("mid_rst_rd_row", sif.rd_row, 0);
    check("mid_rst_rd_col", sif.rd_col, 0);
    check("mid_rst_busy", sif.busy, 1'b0);
    check("mid_rst_done", sif.done, 1'b0);
    check("mid_rst_frame_cnt", sif.frame_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", sif.busy, 1'b0);
    check("post_rst_idle_valid", sif.tile_valid, 1'b0);

    // Plain arena scan.
    scan(0, 1'b0, 1'b1, tiles, dc, fc);
    check("s1_tiles", tiles, 100);
    check("s1_done_cycle", dc, 301);
    check("s1_frame_cnt", fc, 1);
    check("s1_code_0_0", got_code[0], 1);
    check("s1_code_1_1", got_code[11], 2);
    check("s1_code_8_8", got_code[88], 3);
    check("s1_code_4_4", got_code[44], 0);
    check("s1_code_5_7", got_code[57], 1);
    check("s1_last_count", last_cnt, 1);
    check("s1_last_index", last_idx, 99);

    // Bomb merge.
    bomb_m[4][4] = 2'd2;
    bomb_m[1][1] = 2'd1;
    bomb_m[0][5] = 2'd3;
    bomb_m[6][2] = 2'd3;
    scan(0, 1'b0, 1'b1, tiles, dc, fc);
    check("s2_tiles", tiles, 100);
    check("s2_done_cycle", dc, 301);
    check("s2_frame_cnt", fc, 2);
    check("s2_code_4_4", got_code[44], 5);
    check("s2_code_1_1", got_code[11], 7);
    check("s2_code_0_5", got_code[5], 1);
    check("s2_code_6_2", got_code[62], 6);

    // Backpressure on tile (2,4).
    scan(5, 1'b0, 1'b1, tiles, dc, fc);
    check("s3_tiles", tiles, 100);
    check("s3_done_cycle", dc, 306);
    check("s3_frame_cnt", fc, 3);

    // Start while busy.
    scan(0, 1'b1, 1'b1, tiles, dc, fc);
    check("s4_tiles", tiles, 100);
    check("s4_done_cycle", dc, 301);
    check("s4_frame_cnt", fc, 4);
    check("s4_last_count", last_cnt, 1);

    // Frame counter wrap from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("wrap_start_frame_cnt", sif.frame_cnt, 0);
    for (int i = 0; i < 256; i++) begin
      scan(0, 1'b0, 1'b0, tiles, dc, fc);
      if (i == 0) check("wrap_first_frame_cnt", fc, 1);
      if (i == 254) check("wrap_255_frame_cnt", fc, 255);
      if (i == 255) begin
        check("wrap_256_frame_cnt", fc, 0);
        check("wrap_256_done_cycle", dc, 301);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arena_scanner.md
# arena_scanner

Reads the arena and bomb grids that the reset logic initialises and gameplay logic updates, and streams them out one cell at a time as tile codes for the display/render stage. Each scan is triggered by a frame tick. The block issues row-major read addresses to the grid storage, merges each arena cell with its bomb cell into a 3-bit tile code, and hands tiles downstream over a valid/ready handshake. It also counts completed frames.

## Interface
- ROWS, 10, grid rows; row index 0..ROWS-1
- COLS, 10, grid columns; column index 0..COLS-1
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  frame tick; sampled only in IDLE
- rd_row  output  4  grid read row address
- rd_col  output  4  grid read column address
- arena_q  input  2  arena cell at the address presented in the previous cycle (0 blank, 1 block, 2 player A, 3 player B)
- bomb_q  input  2  bomb cell at the address presented in the previous cycle (0 none, 1..3 fuse stage)
- tile_valid  output  1  tile fields valid
- tile_ready  input  1  downstream accepts the tile
- tile_code  output  3  merged cell code
- tile_row  output  4  row of the current tile
- tile_col  output  4  column of the current tile
- tile_last  output  1  current tile is (ROWS-1, COLS-1)
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse when a scan completes
- frame_cnt  output  8  completed-scan count; wraps 255 -> 0

## Operation
- States: IDLE, ADDR, CAPT, SEND, DONE.
- IDLE: busy=0. When start=1, clear the row and column counters to 0 and go to ADDR.
- ADDR: drive rd_row and rd_col from the counters. Go to CAPT.
- CAPT: arena_q and bomb_q are valid. Register tile_code, tile_row, tile_col and tile_last. Go to SEND.
- SEND: tile_valid=1. Hold every tile field and rd_row/rd_col stable while tile_ready=0.
  - On tile_valid && tile_ready with tile_last=1: go to DONE.
  - Otherwise advance col. When col reaches COLS-1, set col=0 and row+1. Go to ADDR.
- DONE: done=1 for one cycle, frame_cnt+1 (modulo 256). Go to IDLE.
- busy=1 in ADDR, CAPT, SEND and DONE.
- Merge rules for tile_code:
  - arena 1/2/3 with bomb 0: code equals arena (1/2/3).
  - arena 0 with bomb 0: code 0.
  - arena 0 with bomb b≠0: code 3+b (4, 5 or 6).
  - arena 2 or 3 with bomb≠0: code 7 (player on bomb).
  - arena 1 with bomb≠0: code 1 (block wins).
- start outside IDLE is ignored; it is not queued.
- Order is row-major: row 0 col 0..COLS-1, then row 1, and so on. Exactly ROWS*COLS tiles per scan.

## Timing
- Reset (asynchronous, takes effect immediately, also mid-scan):
  - state IDLE
  - rd_row=0, rd_col=0
  - tile_valid=0, tile_code=0, tile_row=0, tile_col=0, tile_last=0
  - busy=0, done=0, frame_cnt=0
  - Any in-flight tile is dropped without handshake.
- Read latency: the grid returns data one cycle after the address. The block must not sample arena_q or bomb_q in ADDR.
- Per-cell cost is 3 cycles with tile_ready held at 1. Each stalled SEND cycle adds 1.
- Start sampled high at edge E:
  - busy=1 after E.
  - The first tile_valid is in the 3rd cycle after E (ADDR, CAPT, SEND).
- With tile_ready=1 throughout, done pulses in cycle 3*ROWS*COLS+1 after E, i.e. 301 for 10x10. IDLE follows the next cycle.
- Once tile_valid rises it stays high until accepted.
- DONE and IDLE are separate cycles, so the earliest restart is a start sampled in IDLE.
- frame_cnt updates on the same edge that enters DONE, so it is visible during the done cycle.

## Test plan
- **Reset values:** assert rst mid-cycle during SEND -> all outputs immediately at reset values. After release, start=0 keeps busy=0.
- **Initial arena scan, tile_ready=1:** borders=1, (1,1)=2, (8,8)=3, blocks at (1,3) and (5,7), all bombs 0.
  - Exactly 100 tiles.
  - (0,0) code 1, (1,1) code 2, (8,8) code 3, (4,4) code 0, (5,7) code 1.
  - tile_last only on (9,9).
  - done 301 cycles after the start edge; frame_cnt=1.
- **Bomb merge:** bombs (4,4)=2, (1,1)=1, (0,5)=3.
  - (4,4) code 5, (1,1) code 7, (0,5) code 1.
  - Blank cell with bomb 3 gives code 6.
- **Backpressure:** drop tile_ready for 5 cycles while tile (2,4) is valid.
  - tile_code, tile_row, tile_col, rd_row and rd_col are unchanged for those cycles.
  - Tile (2,5) follows only after acceptance.
  - The scan takes 5 extra cycles.
- **Start while busy:** pulse start at tile (3,0) -> ignored, still 100 tiles, a single done pulse.
- **frame_cnt wrap:** run 256 back-to-back scans -> frame_cnt goes 255 -> 0 on the 256th done.
